parking_counter_multi: RTL and testbench

Multi-lane vehicle occupancy counter: the parametrised successor to the single-entrance two-sensor parking counter. Each lane has an outer sensor A and an inner sensor B. Each lane debounces its sensors and decodes entry (A→AB→B→none) or exit (B→AB→A→none) with a per-lane FSM. A shared saturating occupancy counter drives the LED/status outputs. It sits between the board push-button/sensor pins and the display logic, clocked from the 50 MHz board clock.

---
 rtl/parking_counter_multi.sv | 256 +++++++++++++++++++++++++
 tb/tb_parking_counter_multi.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_counter_multi.sv
// Multi-lane vehicle occupancy counter. Per lane: 2-FF sync + debounce of A/B, entry/exit FSM; shared clamped counter.
// Latency: debounced level DB_CYCLES cycles after the synchroniser, FSM pulse one cycle later, count/sat_err one more.
// Backpressure: none. Lanes never stall each other and all outputs are valid every cycle.
//
// Ports:
//   clk, reset               - rising-edge clock, asynchronous active-high reset
//   botonA/botonB [LANES]    - raw outer/inner sensors, bit i = lane i
//   count/full/empty         - registered occupancy and its decoded limits
//   entry_pulse/exit_pulse   - one-cycle pulse per decoded vehicle entry/exit, per lane
//   seq_err [LANES]          - one-cycle pulse on an illegal sensor transition
//   sat_err                  - one-cycle pulse when the count update was clamped
module parking_counter_multi #(
    parameter int LANES     = 2,
    parameter int CNT_W     = 4,
    parameter int CAPACITY  = 15,
    parameter int DB_CYCLES = 250
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] botonA,
    input  logic [LANES-1:0] botonB,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [LANES-1:0] entry_pulse,
    output logic [LANES-1:0] exit_pulse,
    output logic [LANES-1:0] seq_err,
    output logic             sat_err
);

    localparam int NB  = 2 * LANES;
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int SW  = CNT_W + $clog2(LANES) + 2;

    localparam logic [DBW-1:0]       DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic signed [SW-1:0] CAP_S   = SW'(CAPACITY);

    // ------------------------------------------------------------------
    // Input conditioning. Bit i is lane i's B sensor, bit LANES+i its A.
    // ------------------------------------------------------------------
    logic [NB-1:0]  raw;
    logic [NB-1:0]  sync1_q, sync1_d;
    logic [NB-1:0]  sync2_q, sync2_d;
    logic [NB-1:0]  db_q, db_d;
    logic [DBW-1:0] db_cnt_q [NB];
    logic [DBW-1:0] db_cnt_d [NB];

    assign raw = {botonA, botonB};

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int i = 0; i < NB; i++) begin
            db_cnt_d[i] = '0;
            // Count consecutive cycles of disagreement; a run that breaks
            // before reaching DB_CYCLES restarts from zero.
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < NB; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane sequence FSM on P = {A, B}.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_IN1,      // P = 10
        S_IN2,      // P = 11
        S_IN3,      // P = 01
        S_OUT1,     // P = 01
        S_OUT2,     // P = 11
        S_OUT3,     // P = 10
        S_WAIT_CLR
    } state_t;

    logic [LANES-1:0] entry_d, entry_q;
    logic [LANES-1:0] exit_d, exit_q;
    logic [LANES-1:0] err_d, err_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        state_t     state_q, state_d;
        logic [1:0] p;
        logic       ent_l, ext_l, err_l;

        assign p = {db_q[LANES+g], db_q[g]};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= S_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                S_IDLE: begin
                    case (p)
                        2'b10:   state_d = S_IN1;
                        2'b01:   state_d = S_OUT1;
                        2'b11:   state_d = S_WAIT_CLR;
                        default: state_d = S_IDLE;
                    endcase
                end
                S_IN1: begin
                    case (p)
                        2'b11:   state_d = S_IN2;
                        2'b00:   state_d = S_IDLE;      // backed out
                        2'b01:   state_d = S_WAIT_CLR;
                        default: state_d = S_IN1;
                    endcase
                end
                S_IN2: begin
                    case (p)
                        2'b10:   state_d = S_IN1;
                        2'b01:   state_d = S_IN3;
                        2'b00:   state_d = S_WAIT_CLR;
                        default: state_d = S_IN2;
                    endcase
                end
                S_IN3: begin
                    case (p)
                        2'b11:   state_d = S_IN2;
                        2'b00:   state_d = S_IDLE;      // entry complete
                        2'b10:   state_d = S_WAIT_CLR;
                        default: state_d = S_IN3;
                    endcase
                end
                S_OUT1: begin
                    case (p)
                        2'b11:   state_d = S_OUT2;
                        2'b00:   state_d = S_IDLE;      // backed out
                        2'b10:   state_d = S_WAIT_CLR;
                        default: state_d = S_OUT1;
                    endcase
                end
                S_OUT2: begin
                    case (p)
                        2'b01:   state_d = S_OUT1;
                        2'b10:   state_d = S_OUT3;
                        2'b00:   state_d = S_WAIT_CLR;
                        default: state_d = S_OUT2;
                    endcase
                end
                S_OUT3: begin
                    case (p)
                        2'b11:   state_d = S_OUT2;
                        2'b00:   state_d = S_IDLE;      // exit complete
                        2'b01:   state_d = S_WAIT_CLR;
                        default: state_d = S_OUT3;
                    endcase
                end
                S_WAIT_CLR: begin
                    if (p == 2'b00) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // An error is flagged exactly on the move into WAIT_CLR, so a lane
        // sitting in WAIT_CLR stays silent until released.
        always_comb begin
            ent_l = (state_q == S_IN3)  && (p == 2'b00);
            ext_l = (state_q == S_OUT3) && (p == 2'b00);
            err_l = (state_q != S_WAIT_CLR) && (state_d == S_WAIT_CLR);
        end

        assign entry_d[g] = ent_l;
        assign exit_d[g]  = ext_l;
        assign err_d[g]   = err_l;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
            exit_q  <= '0;
            err_q   <= '0;
        end else begin
            entry_q <= entry_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Shared occupancy counter. Entries and exits of the same cycle net
    // out first; only the net result is clamped.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  sat_q, sat_d;
    logic [SW-1:0]         n_ent, n_ext;
    logic signed [SW-1:0]  sum_d;

    always_comb begin
        n_ent = '0;
        n_ext = '0;
        for (int i = 0; i < LANES; i++) begin
            n_ent = n_ent + SW'(entry_q[i]);
            n_ext = n_ext + SW'(exit_q[i]);
        end
        sum_d   = $signed(SW'(count_q)) + $signed(n_ent) - $signed(n_ext);
        count_d = sum_d[CNT_W-1:0];
        sat_d   = 1'b0;
        if (sum_d[SW-1]) begin
            count_d = '0;
            sat_d   = 1'b1;
        end else if (sum_d > CAP_S) begin
            count_d = CNT_W'(CAPACITY);
            sat_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count       = count_q;
    assign full        = (count_q == CNT_W'(CAPACITY));
    assign empty       = (count_q == '0);
    assign entry_pulse = entry_q;
    assign exit_pulse  = exit_q;
    assign seq_err     = err_q;
    assign sat_err     = sat_q;

endmodule

// File: tb/tb_parking_counter_multi.sv
// Bench for parking_counter_multi: directed lane sequences checked every cycle against a behavioural model.
// Latency: model tracks sync, debounce run length, sequence progress and a clamped integer count.
// Backpressure: none; inputs are driven 1 time unit after the rising edge, outputs compared on the falling edge.
module tb_parking_counter_multi;

    localparam int L   = 2;
    localparam int CW  = 4;
    localparam int CAP = 3;
    localparam int DB  = 4;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic [L-1:0]  botonA = '0;
    logic [L-1:0]  botonB = '0;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [L-1:0]  entry_pulse;
    logic [L-1:0]  exit_pulse;
    logic [L-1:0]  seq_err;
    logic          sat_err;

    parking_counter_multi #(
        .LANES(L), .CNT_W(CW), .CAPACITY(CAP), .DB_CYCLES(DB)
    ) dut (
        .clk(clk), .reset(reset), .botonA(botonA), .botonB(botonB),
        .count(count), .full(full), .empty(empty),
        .entry_pulse(entry_pulse), .exit_pulse(exit_pulse),
        .seq_err(seq_err), .sat_err(sat_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Per sensor: two-stage sample delay, accepted level, length of the
    // current disagreement run. Per lane: mode (0 idle, 1 entering,
    // 2 exiting, 3 waiting for clear) and position along the 3-step path.
    logic [L-1:0] m_a1 = '0, m_a2 = '0, m_adb = '0;
    logic [L-1:0] m_b1 = '0, m_b2 = '0, m_bdb = '0;
    int           m_arun [L];
    int           m_brun [L];
    int           m_mode [L];
    int           m_step [L];
    logic [L-1:0] m_ent = '0, m_ext = '0, m_err = '0;
    int           m_cnt = 0;
    logic         m_sat = 1'b0;

    function automatic logic [1:0] path_pat(input int mode, input int step);
        // entering: 10, 11, 01   exiting: 01, 11, 10
        if (step == 1) return 2'b11;
        if ((mode == 1) == (step == 0)) return 2'b10;
        return 2'b01;
    endfunction

    task automatic model_clear();
        m_a1 = '0; m_a2 = '0; m_adb = '0;
        m_b1 = '0; m_b2 = '0; m_bdb = '0;
        for (int l = 0; l < L; l++) begin
            m_arun[l] = 0; m_brun[l] = 0; m_mode[l] = 0; m_step[l] = 0;
        end
        m_ent = '0; m_ext = '0; m_err = '0; m_cnt = 0; m_sat = 1'b0;
    endtask

    task automatic model_step();
        int t;
        logic [1:0]   p;
        logic [L-1:0] ne, nx, nr;
        t = m_cnt + $countones(m_ent) - $countones(m_ext);
        m_sat = 1'b0;
        if (t < 0)   begin t = 0;   m_sat = 1'b1; end
        if (t > CAP) begin t = CAP; m_sat = 1'b1; end
        m_cnt = t;
        ne = '0; nx = '0; nr = '0;
        for (int l = 0; l < L; l++) begin
            p = {m_adb[l], m_bdb[l]};
            if (m_mode[l] == 3) begin
                if (p == 2'b00) m_mode[l] = 0;
            end else if (m_mode[l] == 0) begin
                if (p == 2'b10)      begin m_mode[l] = 1; m_step[l] = 0; end
                else if (p == 2'b01) begin m_mode[l] = 2; m_step[l] = 0; end
                else if (p == 2'b11) begin m_mode[l] = 3; nr[l] = 1'b1; end
            end else if (p == path_pat(m_mode[l], m_step[l])) begin
                // holding position
            end else if (m_step[l] < 2 && p == path_pat(m_mode[l], m_step[l] + 1)) begin
                m_step[l]++;
            end else if (m_step[l] > 0 && p == path_pat(m_mode[l], m_step[l] - 1)) begin
                m_step[l]--;
            end else if (p == 2'b00 && m_step[l] == 0) begin
                m_mode[l] = 0;
            end else if (p == 2'b00 && m_step[l] == 2) begin
                if (m_mode[l] == 1) ne[l] = 1'b1; else nx[l] = 1'b1;
                m_mode[l] = 0;
            end else begin
                m_mode[l] = 3; nr[l] = 1'b1;
            end
        end
        m_ent = ne; m_ext = nx; m_err = nr;
        for (int l = 0; l < L; l++) begin
            if (m_a2[l] != m_adb[l]) begin
                m_arun[l]++;
                if (m_arun[l] == DB) begin m_adb[l] = m_a2[l]; m_arun[l] = 0; end
            end else m_arun[l] = 0;
            if (m_b2[l] != m_bdb[l]) begin
                m_brun[l]++;
                if (m_brun[l] == DB) begin m_bdb[l] = m_b2[l]; m_brun[l] = 0; end
            end else m_brun[l] = 0;
        end
        m_a2 = m_a1; m_b2 = m_b1;
        m_a1 = botonA; m_b1 = botonB;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    int ent_seen [L];
    int ext_seen [L];
    int err_seen [L];
    int sat_seen = 0;

    initial begin
        for (int l = 0; l < L; l++) begin
            ent_seen[l] = 0; ext_seen[l] = 0; err_seen[l] = 0;
        end
        @(posedge reset);
        forever begin
            @(negedge clk);
            check("count", int'(count), m_cnt);
            check("full", int'(full), int'(m_cnt == CAP));
            check("empty", int'(empty), int'(m_cnt == 0));
            check("entry_pulse", int'(entry_pulse), int'(m_ent));
            check("exit_pulse", int'(exit_pulse), int'(m_ext));
            check("seq_err", int'(seq_err), int'(m_err));
            check("sat_err", int'(sat_err), int'(m_sat));
            for (int l = 0; l < L; l++) begin
                ent_seen[l] += int'(entry_pulse[l]);
                ext_seen[l] += int'(exit_pulse[l]);
                err_seen[l] += int'(seq_err[l]);
            end
            sat_seen += int'(sat_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int lane, input logic a, input logic b);
        botonA[lane] = a;
        botonB[lane] = b;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lane_entry(input int lane);
        drive(lane, 1'b1, 1'b0); hold(20);
        drive(lane, 1'b1, 1'b1); hold(20);
        drive(lane, 1'b0, 1'b1); hold(20);
        drive(lane, 1'b0, 1'b0); hold(20);
    endtask

    task automatic lane_exit(input int lane);
        drive(lane, 1'b0, 1'b1); hold(20);
        drive(lane, 1'b1, 1'b1); hold(20);
        drive(lane, 1'b1, 1'b0); hold(20);
        drive(lane, 1'b0, 1'b0); hold(20);
    endtask

    int snap_ent, snap_ext, snap_err;

    initial begin
        #1 reset = 1'b1;
        hold(2);
        check("reset_count", int'(count), 0);
        check("reset_empty", int'(empty), 1);
        check("reset_full", int'(full), 0);
        reset = 1'b0;
        hold(2);

        // 1: lane 0 entry with exact count latency after B falls
        drive(0, 1'b1, 1'b0); hold(20);
        drive(0, 1'b1, 1'b1); hold(20);
        drive(0, 1'b0, 1'b1); hold(20);
        drive(0, 1'b0, 1'b0);
        hold(DB + 3);
        check("s1_count_before", int'(count), 0);
        hold(1);
        check("s1_count_after", int'(count), 1);
        check("s1_empty", int'(empty), 0);
        hold(20);
        check("s1_entries", ent_seen[0], 1);

        // 2: lane 1 exit
        lane_exit(1);
        check("s2_count", int'(count), 0);
        check("s2_empty", int'(empty), 1);
        check("s2_exits", ext_seen[1], 1);

        // 3: 3-cycle glitch, then back-out
        drive(0, 1'b1, 1'b0); hold(3);
        drive(0, 1'b0, 1'b0); hold(20);
        drive(0, 1'b1, 1'b0); hold(20);
        drive(0, 1'b0, 1'b0); hold(20);
        check("s3_count", int'(count), 0);
        check("s3_entries", ent_seen[0], 1);
        check("s3_errors", err_seen[0], 0);

        // 4: A and B together, entry-shaped walk ignored until release
        drive(0, 1'b1, 1'b1); hold(20);
        check("s4_seq_err", err_seen[0], 1);
        drive(0, 1'b1, 1'b0); hold(20);
        drive(0, 1'b1, 1'b1); hold(20);
        drive(0, 1'b0, 1'b1); hold(20);
        drive(0, 1'b0, 1'b0); hold(20);
        check("s4_ignored", ent_seen[0], 1);
        lane_entry(0);
        check("s4_recovered", int'(count), 1);
        check("s4_errors_once", err_seen[0], 1);

        // 5: saturation from zero, then netted entry+exit at capacity
        lane_exit(1);
        check("s5_zero", int'(count), 0);
        for (int k = 0; k < 4; k++) lane_entry(0);
        check("s5_count", int'(count), 3);
        check("s5_full", int'(full), 1);
        check("s5_sat_once", sat_seen, 1);
        drive(0, 1'b1, 1'b0); drive(1, 1'b0, 1'b1); hold(20);
        drive(0, 1'b1, 1'b1); drive(1, 1'b1, 1'b1); hold(20);
        drive(0, 1'b0, 1'b1); drive(1, 1'b1, 1'b0); hold(20);
        drive(0, 1'b0, 1'b0); drive(1, 1'b0, 1'b0); hold(20);
        check("s5_net_count", int'(count), 3);
        check("s5_net_sat", sat_seen, 1);
        check("s5_entries", ent_seen[0], 7);
        check("s5_exits", ext_seen[1], 3);

        // 6: half-cycle reset while lane 0 sits in the middle of an entry
        lane_exit(1);
        check("s6_count2", int'(count), 2);
        drive(0, 1'b1, 1'b0); hold(20);
        drive(0, 1'b1, 1'b1); hold(20);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0);
        #1;
        check("s6_reset_count", int'(count), 0);
        check("s6_reset_empty", int'(empty), 1);
        @(negedge clk);
        #1 reset = 1'b0;
        snap_ent = ent_seen[0] + ent_seen[1];
        snap_ext = ext_seen[0] + ext_seen[1];
        snap_err = err_seen[0] + err_seen[1];
        hold(30);
        check("s6_no_entry", ent_seen[0] + ent_seen[1], snap_ent);
        check("s6_no_exit", ext_seen[0] + ext_seen[1], snap_ext);
        check("s6_no_err", err_seen[0] + err_seen[1], snap_err);
        check("s6_count_held", int'(count), 0);
        lane_entry(0);
        check("s6_idle_entry", int'(count), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
